// File: rtl/synapse_window_sched_if.sv
// Configuration port of the synapse window scheduler.
// Carries shadow-register writes, the commit request and the status flags
// the scheduler reports back to whoever is configuring the bank.
interface synapse_window_sched_if #(
    parameter int NUM_SYN  = 8,
    parameter int WEIGHT_W = 8,
    parameter int ADDR_W   = $clog2(NUM_SYN + 1)
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic [WEIGHT_W-1:0] cfg_thresh;
    logic                cfg_commit;
    logic                cfg_err;
    logic                commit_pend;

    // Configuring agent: issues writes and commits, observes status.
    modport master (
        output cfg_valid, cfg_addr, cfg_weight, cfg_thresh, cfg_commit,
        input  cfg_ready, cfg_err, commit_pend
    );

    // Scheduler side: accepts writes and commits, reports status.
    modport slave (
        input  cfg_valid, cfg_addr, cfg_weight, cfg_thresh, cfg_commit,
        output cfg_ready, cfg_err, commit_pend
    );
endinterface

// File: rtl/synapse_window_sched.sv
// Window timebase and atomic weight/threshold configurator for a bank of
// NUM_SYN synapses that share one spiking window of LEN cycles.
// Writes land in shadow registers; a commit copies the whole shadow set to
// the active outputs on a window boundary (or on the next edge while idle),
// so the synapses never see a weight change in the middle of a window.
// The address field is one value wider than a plain synapse index so that
// an out-of-range target (flagged with cfg_err) can actually be expressed.
module synapse_window_sched #(
    parameter  int NUM_SYN        = 8,
    parameter  int SPIKING_WINDOW = 16,
    parameter  int WIN_MULT       = 3,
    parameter  int WEIGHT_W       = 8,
    localparam int LEN            = WIN_MULT * SPIKING_WINDOW,
    localparam int CNT_W          = $clog2(LEN),
    localparam int ADDR_W         = $clog2(NUM_SYN + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    synapse_window_sched_if.slave              cfg,
    output logic                               syn_rst_n,
    output logic [NUM_SYN-1:0][WEIGHT_W-1:0]   weight_o,
    output logic [NUM_SYN-1:0][WEIGHT_W-1:0]   thresh_o,
    output logic                               win_start,
    output logic                               win_end,
    output logic [CNT_W-1:0]                   cycle_cnt,
    output logic [15:0]                        win_idx
);

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_SYN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [NUM_SYN-1:0][WEIGHT_W-1:0] bank_t;

    state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]   win_idx_q, win_idx_d;
    logic          win_start_q, win_start_d;
    logic          win_end_q, win_end_d;
    logic          syn_rst_n_q, syn_rst_n_d;
    logic          boundary_s;

    bank_t         shadow_w_q, shadow_w_d;
    bank_t         shadow_t_q, shadow_t_d;
    bank_t         active_w_q, active_w_d;
    bank_t         active_t_q, active_t_d;
    logic          cfg_ready_q, cfg_ready_d;
    logic          cfg_err_q, cfg_err_d;
    logic          commit_pend_q, commit_pend_d;
    logic          accept_s;
    logic          in_range_s;
    logic          apply_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state plus the window timebase derived from it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_idx_d  = win_idx_q;
        boundary_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // The window always completes; enable only matters here.
                    boundary_s = 1'b1;
                    cnt_d      = CNT_ZERO;
                    win_idx_d  = win_idx_q + 16'd1;
                    if (enable) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        // Flags are computed from the next position so they line up with it.
        win_start_d = (state_d == ST_RUN) && (cnt_d == CNT_ZERO);
        win_end_d   = (state_d == ST_RUN) && (cnt_d == CNT_LAST);
        syn_rst_n_d = (state_d == ST_RUN);
    end

    // Shadow writes, commit tracking and the shadow-to-active copy.
    always_comb begin
        accept_s   = cfg.cfg_valid && cfg_ready_q;
        in_range_s = (cfg.cfg_addr < ADDR_LIM);
        // A pending commit lands at a window boundary, or at once when idle.
        apply_s    = commit_pend_q && ((state_q == ST_IDLE) || boundary_s);
        shadow_w_d = shadow_w_q;
        shadow_t_d = shadow_t_q;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (accept_s && (cfg.cfg_addr == ADDR_W'(i))) begin
                shadow_w_d[i] = cfg.cfg_weight;
                shadow_t_d[i] = cfg.cfg_thresh;
            end else begin
                shadow_w_d[i] = shadow_w_q[i];
                shadow_t_d[i] = shadow_t_q[i];
            end
        end
        if (apply_s) begin
            active_w_d = shadow_w_q;
            active_t_d = shadow_t_q;
        end else begin
            active_w_d = active_w_q;
            active_t_d = active_t_q;
        end
        if (apply_s) begin
            commit_pend_d = 1'b0;
        end else if (cfg.cfg_commit) begin
            commit_pend_d = 1'b1;
        end else begin
            commit_pend_d = commit_pend_q;
        end
        // Writes are held off while a commit waits, keeping the set frozen.
        cfg_ready_d = !commit_pend_d;
        cfg_err_d   = accept_s && !in_range_s;
    end

    // Timebase, configuration and active-bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= CNT_ZERO;
            win_idx_q     <= 16'd0;
            win_start_q   <= 1'b0;
            win_end_q     <= 1'b0;
            syn_rst_n_q   <= 1'b0;
            shadow_w_q    <= '0;
            shadow_t_q    <= '0;
            active_w_q    <= '0;
            active_t_q    <= '0;
            cfg_ready_q   <= 1'b1;
            cfg_err_q     <= 1'b0;
            commit_pend_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            win_idx_q     <= win_idx_d;
            win_start_q   <= win_start_d;
            win_end_q     <= win_end_d;
            syn_rst_n_q   <= syn_rst_n_d;
            shadow_w_q    <= shadow_w_d;
            shadow_t_q    <= shadow_t_d;
            active_w_q    <= active_w_d;
            active_t_q    <= active_t_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_err_q     <= cfg_err_d;
            commit_pend_q <= commit_pend_d;
        end
    end

    assign cycle_cnt       = cnt_q;
    assign win_idx         = win_idx_q;
    assign win_start       = win_start_q;
    assign win_end         = win_end_q;
    assign syn_rst_n       = syn_rst_n_q;
    assign weight_o        = active_w_q;
    assign thresh_o        = active_t_q;
    assign cfg.cfg_ready   = cfg_ready_q;
    assign cfg.cfg_err     = cfg_err_q;
    assign cfg.commit_pend = commit_pend_q;

endmodule

// File: tb/tb_synapse_window_sched.sv
// Self-checking bench for synapse_window_sched. Committed weight sets are
// pushed to a scoreboard queue when the commit is driven and popped and
// compared when the scheduler applies them. A small timebase model tracks
// the expected window count.
module tb_synapse_window_sched;
    localparam int NUM_SYN  = 8;
    localparam int WEIGHT_W = 8;
    localparam int LEN      = 48;
    localparam int CNT_W    = 6;
    localparam int ADDR_W   = 4;

    typedef logic [NUM_SYN-1:0][WEIGHT_W-1:0] bank_t;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 syn_rst_n;
    bank_t                weight_o;
    bank_t                thresh_o;
    logic                 win_start;
    logic                 win_end;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [15:0]          win_idx;

    synapse_window_sched_if #(.NUM_SYN(NUM_SYN), .WEIGHT_W(WEIGHT_W)) cfg_bus ();

    synapse_window_sched #(
        .NUM_SYN(NUM_SYN), .SPIKING_WINDOW(16), .WIN_MULT(3), .WEIGHT_W(WEIGHT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg(cfg_bus),
        .syn_rst_n(syn_rst_n), .weight_o(weight_o), .thresh_o(thresh_o),
        .win_start(win_start), .win_end(win_end), .cycle_cnt(cycle_cnt),
        .win_idx(win_idx)
    );

    int    checks = 0;
    int    failures = 0;
    bank_t shadow_w_m, shadow_t_m, act_w_m, act_t_m;
    bank_t exp_w_q[$];
    bank_t exp_t_q[$];
    bank_t ew, et;
    bit    pend_m;
    bit    m_run;
    int    m_cnt;
    logic [15:0] m_idx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one clock, updating the timebase model, then settle.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_run = 1'b0; m_cnt = 0; m_idx = 16'd0;
        end else if (!m_run) begin
            if (enable) begin m_run = 1'b1; m_cnt = 0; end
        end else if (m_cnt == LEN - 1) begin
            m_idx = m_idx + 16'd1; m_cnt = 0; m_run = enable;
        end else begin
            m_cnt++;
        end
        #1;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (cycle_cnt !== CNT_W'(target) && n < 200) begin
            step();
            n++;
        end
        if (cycle_cnt !== CNT_W'(target)) begin
            checks++; failures++;
            $display("FAIL wait_cnt: cycle_cnt=%0d required=%0d", cycle_cnt, target);
        end
    endtask

    task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [WEIGHT_W-1:0] w,
                               input logic [WEIGHT_W-1:0] t);
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_addr   = a;
        cfg_bus.cfg_weight = w;
        cfg_bus.cfg_thresh = t;
        if (!pend_m && a < NUM_SYN) begin
            shadow_w_m[a[2:0]] = w;
            shadow_t_m[a[2:0]] = t;
        end
    endtask

    task automatic push_commit();
        cfg_bus.cfg_commit = 1'b1;
        if (!pend_m) begin
            exp_w_q.push_back(shadow_w_m);
            exp_t_q.push_back(shadow_t_m);
            pend_m = 1'b1;
        end
    endtask

    task automatic idle_bus();
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_commit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; pend_m = 1'b0;
        cfg_bus.cfg_addr = 4'd0; cfg_bus.cfg_weight = 8'd0; cfg_bus.cfg_thresh = 8'd0;
        idle_bus();
        shadow_w_m = '0; shadow_t_m = '0; act_w_m = '0; act_t_m = '0;
        step(); step();
        checks++;
        if ({syn_rst_n, cfg_bus.cfg_ready, cfg_bus.commit_pend, cfg_bus.cfg_err, win_start, win_end} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 010000",
                     {syn_rst_n, cfg_bus.cfg_ready, cfg_bus.commit_pend, cfg_bus.cfg_err, win_start, win_end});
        end
        checks++;
        if (cycle_cnt !== 6'd0 || win_idx !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: cycle_cnt=%0d win_idx=%0d required 0 0", cycle_cnt, win_idx);
        end
        checks++;
        if (weight_o !== 64'd0 || thresh_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_banks: weight_o=%h thresh_o=%h required 0", weight_o, thresh_o);
        end
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (syn_rst_n !== 1'b0 || win_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: syn_rst_n=%b win_start=%b required 0 0", syn_rst_n, win_start);
        end
    endtask

    task automatic test_timebase();
        int end_at = -1;
        enable = 1'b1;
        step();
        checks++;
        if (win_start !== 1'b1 || syn_rst_n !== 1'b1 || cycle_cnt !== 6'd0 || win_end !== 1'b0) begin
            failures++;
            $display("FAIL first_window: win_start=%b syn_rst_n=%b cnt=%0d win_end=%b required 1 1 0 0",
                     win_start, syn_rst_n, cycle_cnt, win_end);
        end
        for (int k = 1; k < LEN; k++) begin
            step();
            if (win_end === 1'b1 && end_at < 0) end_at = k;
        end
        checks++;
        if (end_at != 47 || cycle_cnt !== 6'd47) begin
            failures++;
            $display("FAIL win_end_timing: win_end first at %0d cnt=%0d required 47 47", end_at, cycle_cnt);
        end
        step();
        checks++;
        if (win_idx !== 16'd1 || win_start !== 1'b1 || cycle_cnt !== 6'd0) begin
            failures++;
            $display("FAIL boundary: win_idx=%0d win_start=%b cnt=%0d required 1 1 0", win_idx, win_start, cycle_cnt);
        end
    endtask

    task automatic test_commit_run();
        int bad = 0;
        wait_cnt(2);
        drive_write(4'd3, 8'h20, 8'h10);
        step();
        idle_bus();
        checks++;
        if (cfg_bus.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL good_write_err: cfg_err=%b required 0", cfg_bus.cfg_err);
        end
        wait_cnt(10);
        push_commit();
        step();
        idle_bus();
        checks++;
        if (cfg_bus.commit_pend !== 1'b1 || cfg_bus.cfg_ready !== 1'b0 || cycle_cnt !== 6'd11) begin
            failures++;
            $display("FAIL pend_rise: commit_pend=%b cfg_ready=%b cnt=%0d required 1 0 11",
                     cfg_bus.commit_pend, cfg_bus.cfg_ready, cycle_cnt);
        end
        for (int k = 0; k < 60 && cycle_cnt !== 6'd47; k++) begin
            if (weight_o[3] !== act_w_m[3] || cfg_bus.cfg_ready !== 1'b0) bad++;
            step();
        end
        if (weight_o[3] !== act_w_m[3] || cfg_bus.cfg_ready !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_window_hold: %0d cycles with early weight or cfg_ready high, required 0", bad);
        end
        step();
        ew = exp_w_q.pop_front(); et = exp_t_q.pop_front(); pend_m = 1'b0;
        checks++;
        if (weight_o !== ew || thresh_o !== et || cycle_cnt !== 6'd0) begin
            failures++;
            $display("FAIL commit_run_apply: weight_o=%h thresh_o=%h cnt=%0d required %h %h 0",
                     weight_o, thresh_o, cycle_cnt, ew, et);
        end
        act_w_m = ew; act_t_m = et;
        checks++;
        if (cfg_bus.cfg_ready !== 1'b1 || cfg_bus.commit_pend !== 1'b0 || weight_o[3] !== 8'h20) begin
            failures++;
            $display("FAIL commit_run_restore: cfg_ready=%b commit_pend=%b w3=%h required 1 0 20",
                     cfg_bus.cfg_ready, cfg_bus.commit_pend, weight_o[3]);
        end
    endtask

    task automatic test_commit_same_cycle();
        wait_cnt(3);
        drive_write(4'd5, 8'h55, 8'h2A);
        push_commit();
        step();
        idle_bus();
        wait_cnt(6);
        drive_write(4'd1, 8'h77, 8'h77);
        push_commit();
        step();
        idle_bus();
        wait_cnt(47);
        step();
        ew = exp_w_q.pop_front(); et = exp_t_q.pop_front(); pend_m = 1'b0;
        checks++;
        if (weight_o !== ew || thresh_o !== et) begin
            failures++;
            $display("FAIL same_cycle_apply: weight_o=%h thresh_o=%h required %h %h", weight_o, thresh_o, ew, et);
        end
        act_w_m = ew; act_t_m = et;
        step(); step(); step();
        checks++;
        if (cfg_bus.commit_pend !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL double_commit: commit_pend=%b cfg_ready=%b required 0 1",
                     cfg_bus.commit_pend, cfg_bus.cfg_ready);
        end
    endtask

    task automatic test_bad_addr();
        wait_cnt(8);
        drive_write(4'd8, 8'hFF, 8'hFF);
        step();
        idle_bus();
        checks++;
        if (cfg_bus.cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_addr_err: cfg_err=%b required 1", cfg_bus.cfg_err);
        end
        step();
        checks++;
        if (cfg_bus.cfg_err !== 1'b0 || weight_o !== act_w_m) begin
            failures++;
            $display("FAIL bad_addr_pulse: cfg_err=%b weight_o=%h required 0 %h", cfg_bus.cfg_err, weight_o, act_w_m);
        end
        wait_cnt(12);
        push_commit();
        step();
        idle_bus();
        wait_cnt(47);
        step();
        ew = exp_w_q.pop_front(); et = exp_t_q.pop_front(); pend_m = 1'b0;
        checks++;
        if (weight_o !== ew || thresh_o !== et) begin
            failures++;
            $display("FAIL bad_addr_shadow: weight_o=%h thresh_o=%h required %h %h", weight_o, thresh_o, ew, et);
        end
        act_w_m = ew; act_t_m = et;
    endtask

    task automatic test_commit_at_boundary();
        wait_cnt(40);
        drive_write(4'd6, 8'h66, 8'h33);
        step();
        idle_bus();
        wait_cnt(47);
        push_commit();
        step();
        idle_bus();
        checks++;
        if (weight_o !== act_w_m || cfg_bus.commit_pend !== 1'b1) begin
            failures++;
            $display("FAIL boundary_defer: weight_o=%h commit_pend=%b required %h 1", weight_o, cfg_bus.commit_pend, act_w_m);
        end
        wait_cnt(47);
        step();
        ew = exp_w_q.pop_front(); et = exp_t_q.pop_front(); pend_m = 1'b0;
        checks++;
        if (weight_o !== ew || thresh_o !== et) begin
            failures++;
            $display("FAIL boundary_late_apply: weight_o=%h thresh_o=%h required %h %h", weight_o, thresh_o, ew, et);
        end
        act_w_m = ew; act_t_m = et;
    endtask

    task automatic test_enable_drop();
        int bad = 0;
        wait_cnt(5);
        enable = 1'b0;
        for (int k = 0; k < 60 && cycle_cnt !== 6'd47; k++) begin
            if (syn_rst_n !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0 || win_end !== 1'b1 || syn_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL drop_completes: early stops=%0d win_end=%b syn_rst_n=%b required 0 1 1", bad, win_end, syn_rst_n);
        end
        step();
        checks++;
        if (syn_rst_n !== 1'b0 || win_start !== 1'b0 || cycle_cnt !== 6'd0 || win_idx !== m_idx) begin
            failures++;
            $display("FAIL drop_idle: syn_rst_n=%b win_start=%b cnt=%0d win_idx=%0d required 0 0 0 %0d",
                     syn_rst_n, win_start, cycle_cnt, win_idx, m_idx);
        end
        drive_write(4'd0, 8'h11, 8'h22);
        push_commit();
        step();
        idle_bus();
        checks++;
        if (cfg_bus.commit_pend !== 1'b1 || weight_o !== act_w_m) begin
            failures++;
            $display("FAIL idle_pend: commit_pend=%b weight_o=%h required 1 %h", cfg_bus.commit_pend, weight_o, act_w_m);
        end
        step();
        ew = exp_w_q.pop_front(); et = exp_t_q.pop_front(); pend_m = 1'b0;
        checks++;
        if (weight_o !== ew || thresh_o !== et || cfg_bus.commit_pend !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_apply: weight_o=%h thresh_o=%h pend=%b ready=%b required %h %h 0 1",
                     weight_o, thresh_o, cfg_bus.commit_pend, cfg_bus.cfg_ready, ew, et);
        end
        act_w_m = ew; act_t_m = et;
        enable = 1'b1;
        step();
        checks++;
        if (win_start !== 1'b1 || syn_rst_n !== 1'b1 || cycle_cnt !== 6'd0) begin
            failures++;
            $display("FAIL reenable: win_start=%b syn_rst_n=%b cnt=%0d required 1 1 0", win_start, syn_rst_n, cycle_cnt);
        end
    endtask

    task automatic test_reset_mid();
        wait_cnt(3);
        drive_write(4'd2, 8'h99, 8'h88);
        push_commit();
        step();
        idle_bus();
        wait_cnt(20);
        checks++;
        if (cfg_bus.commit_pend !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pend: commit_pend=%b required 1", cfg_bus.commit_pend);
        end
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        checks++;
        if ({syn_rst_n, cfg_bus.cfg_ready, cfg_bus.commit_pend, cfg_bus.cfg_err, win_start, win_end} !== 6'b010000
            || cycle_cnt !== 6'd0 || win_idx !== 16'd0 || weight_o !== 64'd0 || thresh_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_clear: flags=%b cnt=%0d idx=%0d w=%h t=%h required 010000 0 0 0 0",
                     {syn_rst_n, cfg_bus.cfg_ready, cfg_bus.commit_pend, cfg_bus.cfg_err, win_start, win_end},
                     cycle_cnt, win_idx, weight_o, thresh_o);
        end
        exp_w_q.delete(); exp_t_q.delete(); pend_m = 1'b0;
        shadow_w_m = '0; shadow_t_m = '0; act_w_m = '0; act_t_m = '0;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        checks++;
        if (weight_o !== 64'd0 || cfg_bus.commit_pend !== 1'b0 || syn_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_lost: weight_o=%h pend=%b syn_rst_n=%b required 0 0 0",
                     weight_o, cfg_bus.commit_pend, syn_rst_n);
        end
        push_commit();
        step();
        idle_bus();
        step();
        ew = exp_w_q.pop_front(); et = exp_t_q.pop_front(); pend_m = 1'b0;
        checks++;
        if (weight_o !== ew || thresh_o !== et) begin
            failures++;
            $display("FAIL reset_mid_shadow: weight_o=%h thresh_o=%h required %h %h", weight_o, thresh_o, ew, et);
        end
    endtask

    initial begin : main
        test_reset();
        test_timebase();
        test_commit_run();
        test_commit_same_cycle();
        test_bad_addr();
        test_commit_at_boundary();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
